fp16_fma_arbiter: RTL
=====================

FP16_FMA_ARBITER -- requirements
Module: fp16_fma_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (fixed 4 in this revision).
REQ-002 SHALL have parameter LATENCY, default 1, number of clock edges from FP16 exponent FMA unit operand inputs to its outputs (legal range 1-4).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  4  per-requester operation request.
REQ-006 SHALL have port req_ready  output  4  per-requester grant (combinational).
REQ-007 SHALL have ports req_a_exp, req_b_exp and req_c_exp  input  20 each  packed per-requester 5-bit exponents, requester i at bits [5i+4:5i].
REQ-008 SHALL have port hold  input  1  suppresses new grants.
REQ-009 SHALL have ports fma_a_exp, fma_b_exp and fma_c_exp  output  5 each  operands to the shared FMA exponent unit.
REQ-010 SHALL have ports fma_ab_exp and fma_c_shift  input  6 each (signed), plus fma_ab_inf and fma_ab_zero  input  1 each  unit results.
REQ-011 SHALL have port resp_valid  output  1  response strobe.
REQ-012 SHALL have port resp_id  output  2  requester index of the response.
REQ-013 SHALL have ports resp_ab_exp and resp_c_shift  output  6 each (signed), plus resp_ab_inf and resp_ab_zero  output  1 each  response data.
REQ-014 SHALL have port busy  output  1  high while any issued operation has no response yet.

Function
REQ-015 SHALL grant at most one requester per cycle; req_ready[i]=1 only if req_valid[i]=1, hold=0, rst=0 and i wins arbitration.
REQ-016 SHALL use round-robin arbitration: the search starts at (last granted index + 1) mod 4 and proceeds upward with wrap-around.
REQ-017 SHALL define an issue as req_valid[i] & req_ready[i] in cycle t; the requester's operands SHALL appear on fma_* in cycle t+1.
REQ-018 SHALL drive fma_*_exp to 0 in any cycle following a cycle with no issue.
REQ-019 SHALL carry a valid bit and 2-bit tag through a LATENCY+1 stage shift register aligned to the unit; fma_* results SHALL be sampled in cycle t+1+LATENCY.
REQ-020 SHALL register responses: resp_valid=1 for exactly one cycle t+2+LATENCY, with resp_id equal to the issuing index and data equal to the unit outputs sampled per REQ-019.
REQ-021 SHALL drive all resp data fields to 0 whenever resp_valid=0.
REQ-022 SHALL sustain one issue per cycle back-to-back, with responses in issue order and no bubbles inserted.
REQ-023 SHALL, while hold=1, issue nothing; in-flight operations still complete, and the round-robin pointer is unchanged.
REQ-024 SHALL drive busy = OR of all pipeline valid bits plus the resp_valid stage.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, clear every pipeline valid bit and tag, set the round-robin pointer so requester 0 has highest priority, and set fma_*=0, resp_*=0 and busy=0.
REQ-026 SHALL force req_ready=0 while rst=1; operations issued before reset SHALL never produce a response.

Configuration
REQ-027 SHALL, with macro FP16_FMA_ARB_PERF_EN defined, add output grant_cnt (64 bits, four 16-bit per-requester counters, requester i at [16i+15:16i]); each counter increments on that requester's issue, saturates at 0xFFFF and is cleared by rst.
REQ-028 SHALL, without FP16_FMA_ARB_PERF_EN, omit port grant_cnt and all counter logic.

Verification
REQ-029 SHALL test a single request: unit model with LATENCY=1, ab_exp=a+b-15, c_shift=ab_exp-c; req 2 issues a=3, b=1, c=0 at cycle 0 -> fma_a_exp=3 in cycle 1; in cycle 3 resp_valid=1, resp_id=2, resp_ab_exp=-11, resp_c_shift=-11; busy high in cycles 1-3.
REQ-030 SHALL test round-robin: all four req_valid held high from reset -> grant order 0,1,2,3,0,1; responses appear on consecutive cycles with ids 0,1,2,3,0,1.
REQ-031 SHALL test hold: hold=1 for 3 cycles with req 1 valid -> req_ready=0 throughout; after hold drops, req 1 is granted first if the pointer favours it, and the in-flight response is unaffected.
REQ-032 SHALL test reset mid-operation: issue at cycle 0, rst=1 in cycle 1 -> no resp_valid ever, busy=0 after reset, next grant goes to requester 0 when all requesters are valid.
REQ-033 SHALL test counters with FP16_FMA_ARB_PERF_EN: 70000 issues from requester 3 -> grant_cnt[63:48]=0xFFFF, other counters 0.

Source files
------------

// File: rtl/fp16_fma_arbiter.sv
`default_nettype none
// ============================================================================
// fp16_fma_arbiter : round-robin sharing of one FP16 exponent FMA unit by 4
// requesters. Optional macro FP16_FMA_ARB_PERF_EN adds grant counters.
// Revision : 1.0
// ============================================================================
module fp16_fma_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [5*NREQ-1:0]   req_a_exp,
  input  logic [5*NREQ-1:0]   req_b_exp,
  input  logic [5*NREQ-1:0]   req_c_exp,
  input  logic                hold,
  output logic [4:0]          fma_a_exp,
  output logic [4:0]          fma_b_exp,
  output logic [4:0]          fma_c_exp,
  input  logic signed [5:0]   fma_ab_exp,
  input  logic signed [5:0]   fma_c_shift,
  input  logic                fma_ab_inf,
  input  logic                fma_ab_zero,
  output logic                resp_valid,
  output logic [1:0]          resp_id,
  output logic signed [5:0]   resp_ab_exp,
  output logic signed [5:0]   resp_c_shift,
  output logic                resp_ab_inf,
  output logic                resp_ab_zero,
  output logic                busy
`ifdef FP16_FMA_ARB_PERF_EN
  ,
  output logic [16*NREQ-1:0]  grant_cnt
`endif
);

  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         grant_idx;
  logic               grant_any;
  logic               issue;
  logic [4:0]         op_a, op_b, op_c;
  logic [4:0]         fma_a_q, fma_b_q, fma_c_q;
  logic [LATENCY:0]   vld_q;
  logic [LATENCY:0][1:0] tag_q;
  logic               resp_valid_q;
  logic [1:0]         resp_id_q;
  logic signed [5:0]  resp_ab_q, resp_cs_q;
  logic               resp_inf_q, resp_zero_q;

  // ptr_q holds the highest-priority index, i.e. last grant + 1.
  always_comb begin
    grant_idx = 2'd0;
    grant_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && req_valid[ptr_q + 2'(k)]) begin
        grant_any = 1'b1;
        grant_idx = ptr_q + 2'(k);
      end
    end
  end

  assign issue     = grant_any & ~hold & ~rst;
  assign req_ready = issue ? (NREQ'(1) << grant_idx) : '0;
  assign ptr_d     = issue ? grant_idx + 2'd1 : ptr_q;

  always_comb begin
    op_a = 5'd0;
    op_b = 5'd0;
    op_c = 5'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == 2'(i)) begin
        op_a = req_a_exp[5*i +: 5];
        op_b = req_b_exp[5*i +: 5];
        op_c = req_c_exp[5*i +: 5];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= 2'd0;
      fma_a_q <= 5'd0;
      fma_b_q <= 5'd0;
      fma_c_q <= 5'd0;
      vld_q   <= '0;
      tag_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      fma_a_q <= issue ? op_a : 5'd0;
      fma_b_q <= issue ? op_b : 5'd0;
      fma_c_q <= issue ? op_c : 5'd0;
      vld_q   <= {vld_q[LATENCY-1:0], issue};
      tag_q   <= {tag_q[LATENCY-1:0], (issue ? grant_idx : 2'd0)};
    end
  end

  // Last pipeline stage lines up with the unit's result for that operation.
  always_ff @(posedge clk) begin
    if (rst || !vld_q[LATENCY]) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= 2'd0;
      resp_ab_q    <= 6'sd0;
      resp_cs_q    <= 6'sd0;
      resp_inf_q   <= 1'b0;
      resp_zero_q  <= 1'b0;
    end else begin
      resp_valid_q <= 1'b1;
      resp_id_q    <= tag_q[LATENCY];
      resp_ab_q    <= fma_ab_exp;
      resp_cs_q    <= fma_c_shift;
      resp_inf_q   <= fma_ab_inf;
      resp_zero_q  <= fma_ab_zero;
    end
  end

  assign fma_a_exp    = fma_a_q;
  assign fma_b_exp    = fma_b_q;
  assign fma_c_exp    = fma_c_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_ab_exp  = resp_ab_q;
  assign resp_c_shift = resp_cs_q;
  assign resp_ab_inf  = resp_inf_q;
  assign resp_ab_zero = resp_zero_q;
  assign busy         = (|vld_q) | resp_valid_q;

`ifdef FP16_FMA_ARB_PERF_EN
  logic [NREQ-1:0][15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (issue && grant_idx == 2'(i) && cnt_q[i] != 16'hFFFF)
          cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule
`default_nettype wire
